// File: rtl/updown_counter_mod_if.sv
// Driver/monitor bundle for updown_counter_mod: control inputs plus count and status outputs.
// The master side drives the controls; the slave side is the counter itself.
interface updown_counter_mod_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  out, tc, wrap, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output out, tc, wrap, ovf
  );
endinterface

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, clear, enable, wrap-or-saturate limits
// and terminal-count / wrap-pulse / sticky-overflow status.
module updown_counter_mod #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MOD_VAL  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input logic                clk,
  input logic                rst_l,
  updown_counter_mod_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be in 2..32");
  end
  if (MOD_VAL < 2 || MOD_VAL > (64'(1) << WIDTH)) begin : g_bad_mod
    $error("updown_counter_mod: MOD_VAL must be in 2..2**WIDTH");
  end

  // Limits held one bit wider so MOD_VAL = 2**WIDTH compares without truncation.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MOD_VAL - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   ld_ext;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign cnt_ext      = {1'b0, cnt_q};
  assign ld_ext       = {1'b0, bus.load_val};
  assign at_max       = (cnt_ext == MAX_EXT);
  assign at_zero      = (cnt_ext == '0);
  assign load_clamped = (ld_ext > MAX_EXT) ? MAX_VAL : bus.load_val;

  // Steps only happen strictly inside the limits, so a WIDTH-bit +/-1 cannot overflow.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      cnt_d = load_clamped;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_max) begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            cnt_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.out  = cnt_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  assign bus.tc   = bus.up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: three instances (mod-10 wrap, mod-10 saturate, mod-16 wrap)
// share one stimulus stream and are compared every cycle against an arithmetic model.
module tb_updown_counter_mod;

  logic       clk;
  logic       rst_l;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up_dn;

  int n_chk;
  int n_fail;

  updown_counter_mod_if #(.WIDTH(4)) if0 ();
  updown_counter_mod_if #(.WIDTH(4)) if1 ();
  updown_counter_mod_if #(.WIDTH(4)) if2 ();

  assign if0.clr = clr;  assign if0.load = load;  assign if0.load_val = load_val;
  assign if0.en  = en;   assign if0.up_dn = up_dn;
  assign if1.clr = clr;  assign if1.load = load;  assign if1.load_val = load_val;
  assign if1.en  = en;   assign if1.up_dn = up_dn;
  assign if2.clr = clr;  assign if2.load = load;  assign if2.load_val = load_val;
  assign if2.en  = en;   assign if2.up_dn = up_dn;

  updown_counter_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b0)) dut0 (.clk(clk), .rst_l(rst_l), .bus(if0));
  updown_counter_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b1)) dut1 (.clk(clk), .rst_l(rst_l), .bus(if1));
  updown_counter_mod #(.WIDTH(4), .MOD_VAL(16), .SATURATE(1'b0)) dut2 (.clk(clk), .rst_l(rst_l), .bus(if2));

  logic [3:0] d_out [3];
  logic       d_tc  [3];
  logic       d_wrap[3];
  logic       d_ovf [3];

  assign d_out[0] = if0.out;  assign d_tc[0] = if0.tc;  assign d_wrap[0] = if0.wrap;  assign d_ovf[0] = if0.ovf;
  assign d_out[1] = if1.out;  assign d_tc[1] = if1.tc;  assign d_wrap[1] = if1.wrap;  assign d_ovf[1] = if1.ovf;
  assign d_out[2] = if2.out;  assign d_tc[2] = if2.tc;  assign d_wrap[2] = if2.wrap;  assign d_ovf[2] = if2.ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mod_of(int i);
    return (i == 2) ? 16 : 10;
  endfunction

  function automatic bit sat_of(int i);
    return (i == 1);
  endfunction

  // Reference: count kept as a plain integer in 0..M-1; any step leaving that range is a limit hit.
  int m_out [3] = '{0, 0, 0};
  bit m_wrap[3] = '{0, 0, 0};
  bit m_ovf [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_l) begin
    int m;
    int nxt;
    for (int i = 0; i < 3; i++) begin
      m = mod_of(i);
      if (!rst_l) begin
        m_out[i] <= 0; m_wrap[i] <= 0; m_ovf[i] <= 0;
      end else if (clr) begin
        m_out[i] <= 0; m_wrap[i] <= 0; m_ovf[i] <= 0;
      end else if (load) begin
        m_out[i]  <= (int'(load_val) >= m) ? m - 1 : int'(load_val);
        m_wrap[i] <= 0;
      end else if (en) begin
        nxt = m_out[i] + (up_dn ? 1 : -1);
        if (nxt < 0 || nxt >= m) begin
          m_ovf[i] <= 1;
          if (sat_of(i)) begin
            m_wrap[i] <= 0;
          end else begin
            m_out[i]  <= (nxt + m) % m;
            m_wrap[i] <= 1;
          end
        end else begin
          m_out[i]  <= nxt;
          m_wrap[i] <= 0;
        end
      end else begin
        m_wrap[i] <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model out[%0d]", i),  32'(d_out[i]),  32'(m_out[i]));
      chk($sformatf("model wrap[%0d]", i), 32'(d_wrap[i]), 32'(m_wrap[i]));
      chk($sformatf("model ovf[%0d]", i),  32'(d_ovf[i]),  32'(m_ovf[i]));
      chk($sformatf("model tc[%0d]", i),   32'(d_tc[i]),
          32'(up_dn ? (m_out[i] == mod_of(i) - 1) : (m_out[i] == 0)));
    end
  end

  task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit u);
    clr = c; load = l; load_val = 4'(lv); en = e; up_dn = u;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_l  = 1'b1;
    drive(0, 0, 0, 0, 1);
    #3 rst_l = 1'b0;
    #1;
    chk("reset out", 32'(d_out[0]), 0);
    chk("reset tc up", 32'(d_tc[0]), 0);
    up_dn = 1'b0;
    #1;
    chk("reset tc down", 32'(d_tc[0]), 1);

    // async reset mid-count
    tick();
    rst_l = 1'b1;
    drive(0, 0, 0, 1, 1);
    repeat (7) tick();
    chk("count to 7", 32'(d_out[0]), 7);
    #1 rst_l = 1'b0;
    #1;
    chk("async rst out", 32'(d_out[0]), 0);
    chk("async rst wrap", 32'(d_wrap[0]), 0);
    chk("async rst ovf", 32'(d_ovf[0]), 0);
    tick();
    rst_l = 1'b1;
    tick();
    chk("first edge after rst", 32'(d_out[0]), 1);

    // up wrap
    drive(1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    repeat (9) tick();
    chk("up reach 9", 32'(d_out[0]), 9);
    chk("up tc at 9", 32'(d_tc[0]), 1);
    chk("up no wrap at 9", 32'(d_wrap[0]), 0);
    tick();
    chk("up wrap out", 32'(d_out[0]), 0);
    chk("up wrap pulse", 32'(d_wrap[0]), 1);
    chk("up wrap ovf", 32'(d_ovf[0]), 1);
    drive(0, 0, 0, 0, 1);
    tick();
    chk("wrap one cycle", 32'(d_wrap[0]), 0);
    chk("ovf sticky", 32'(d_ovf[0]), 1);

    // down wrap, direction change, saturate at zero
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    tick();
    chk("load 0 tc", 32'(d_tc[0]), 1);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("down wrap out", 32'(d_out[0]), 9);
    chk("down wrap pulse", 32'(d_wrap[0]), 1);
    chk("down wrap ovf", 32'(d_ovf[0]), 1);
    chk("sat down out", 32'(d_out[1]), 0);
    chk("sat down ovf", 32'(d_ovf[1]), 1);
    chk("sat down wrap", 32'(d_wrap[1]), 0);
    drive(0, 0, 0, 0, 1);
    #1;
    chk("tc on dir toggle", 32'(d_tc[0]), 1);

    // saturate up
    drive(1, 0, 0, 0, 1);
    tick();
    drive(0, 1, 8, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    chk("sat up e1 out", 32'(d_out[1]), 9);
    chk("sat up e1 ovf", 32'(d_ovf[1]), 0);
    tick();
    chk("sat up e2 out", 32'(d_out[1]), 9);
    chk("sat up e2 ovf", 32'(d_ovf[1]), 1);
    chk("sat up e2 wrap", 32'(d_wrap[1]), 0);
    tick();
    chk("sat up e3 out", 32'(d_out[1]), 9);

    // priority and clamp
    drive(1, 1, 5, 1, 1);
    tick();
    chk("clr wins out", 32'(d_out[0]), 0);
    chk("clr wins ovf", 32'(d_ovf[0]), 0);
    drive(0, 1, 5, 1, 1);
    tick();
    chk("load over en", 32'(d_out[0]), 5);
    drive(0, 1, 12, 0, 1);
    tick();
    chk("load clamp mod10", 32'(d_out[0]), 9);
    chk("load no clamp mod16", 32'(d_out[2]), 12);

    // hold with direction toggling
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, k[0]);
      tick();
      chk("hold out", 32'(d_out[0]), 9);
      chk("hold wrap", 32'(d_wrap[0]), 0);
    end

    // full-range modulus
    drive(0, 1, 14, 0, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    chk("mod16 at 15", 32'(d_out[2]), 15);
    chk("mod16 no wrap at 15", 32'(d_wrap[2]), 0);
    chk("mod16 tc at 15", 32'(d_tc[2]), 1);
    tick();
    chk("mod16 wrap out", 32'(d_out[2]), 0);
    chk("mod16 wrap pulse", 32'(d_wrap[2]), 1);

    // back-to-back wraps on mod-10 at the bottom: down from 0 repeatedly is not continuous,
    // so randomised traffic covers the remaining mix
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 63) == 0) begin
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
      end else begin
        tick();
      end
    end

    drive(0, 0, 0, 0, 1);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
